// File: rtl/vram_arbiter.sv
// Frame-RAM arbiter: prefetches display words ahead of the beam and serves CPU accesses in idle slots.
// Optional statistics counters are compiled in with `define VRAM_ARB_STATS_EN.
module vram_arbiter #(
   parameter int unsigned RAM_WIDTH               = 16,
   parameter int unsigned ADDR_W                  = 10,
   parameter int unsigned BITS_PER_MEMORY_PIXEL_X = 2,
   parameter int unsigned BITS_PER_MEMORY_PIXEL_Y = 2
) (
   input  logic                 CLK_50,
   input  logic                 reset,
   input  logic [9:0]           pixel_x,
   input  logic [9:0]           pixel_y,
   output logic [RAM_WIDTH-1:0] pixel_out,
   output logic                 underrun,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [ADDR_W-1:0]    cpu_addr,
   input  logic [RAM_WIDTH-1:0] cpu_wdata,
   output logic                 cpu_ready,
   output logic                 cpu_rvalid,
   output logic [RAM_WIDTH-1:0] cpu_rdata,
   output logic [ADDR_W-1:0]    ram_addr,
   output logic                 ram_we,
   output logic [RAM_WIDTH-1:0] ram_wdata,
   input  logic [RAM_WIDTH-1:0] ram_rdata
`ifdef VRAM_ARB_STATS_EN
   ,
   output logic [15:0]          underrun_cnt,
   output logic [15:0]          cpu_stall_cnt
`endif
);

   localparam int unsigned PPW     = RAM_WIDTH << BITS_PER_MEMORY_PIXEL_X;
   localparam int unsigned PPW_LOG = $clog2(PPW);
   localparam int unsigned WPR     = 512 / PPW;
   localparam int unsigned ROWS    = 384 >> BITS_PER_MEMORY_PIXEL_Y;
   localparam int unsigned X_MAX   = 512;
   localparam int unsigned Y_MAX   = 384;

   typedef enum logic [2:0] {
      S_IDLE, S_VGA_RD, S_VGA_CAP, S_CPU_RD, S_CPU_CAP, S_CPU_WR
   } state_t;

   state_t                r_state, w_state_nx;
   logic                  r_pf_valid, r_out_valid;
   logic [ADDR_W-1:0]     r_pf_tag, r_out_tag;
   logic [RAM_WIDTH-1:0]  r_pf_data;

   logic [10:0]           w_x_next, w_y_next, w_row_cur, w_row_tgt, w_col_tgt;
   logic [ADDR_W-1:0]     w_cur_addr, w_tgt_addr;
   logic                  w_in_bounds, w_vga_pend;
   logic                  w_wr_hit_pf, w_wr_hit_out, w_disp_chk, w_disp_hit, w_miss;
   logic [RAM_WIDTH-1:0]  w_pf_data_eff;
   logic [ADDR_W-1:0]     w_ram_addr_d;
   logic [RAM_WIDTH-1:0]  w_ram_wdata_d;
   logic                  w_ram_we_d, w_cpu_ready_d;

   function automatic logic [ADDR_W-1:0] f_addr(input logic [10:0] row, input logic [10:0] col);
      return ADDR_W'(32'(row) * WPR + 32'(col));
   endfunction

   // Beam-to-word mapping; at end of line the target is word 0 of the row the next line reads
   always_comb begin
      w_x_next    = 11'(pixel_x) + 11'(PPW);
      w_y_next    = 11'(pixel_y) + 11'd1;
      w_row_cur   = 11'(pixel_y >> BITS_PER_MEMORY_PIXEL_Y);
      w_in_bounds = (pixel_x < 10'(X_MAX)) && (pixel_y < 10'(Y_MAX));
      w_cur_addr  = f_addr(w_row_cur, 11'(pixel_x >> PPW_LOG));
      if (w_x_next < 11'(X_MAX)) begin
         w_row_tgt = w_row_cur;
         w_col_tgt = w_x_next >> PPW_LOG;
      end else begin
         w_row_tgt = w_y_next >> BITS_PER_MEMORY_PIXEL_Y;
         w_col_tgt = '0;
      end
      w_tgt_addr  = (w_row_tgt >= 11'(ROWS)) ? '0 : f_addr(w_row_tgt, w_col_tgt);
      w_vga_pend  = !r_pf_valid || (w_tgt_addr != r_pf_tag);
   end

   always_ff @(posedge CLK_50) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_vga_pend)   w_state_nx = S_VGA_RD;
            else if (cpu_req) w_state_nx = cpu_we ? S_CPU_WR : S_CPU_RD;
         end
         S_VGA_RD:  w_state_nx = S_VGA_CAP;
         S_VGA_CAP: w_state_nx = S_IDLE;
         S_CPU_RD:  w_state_nx = S_CPU_CAP;
         S_CPU_CAP: w_state_nx = S_IDLE;
         S_CPU_WR:  w_state_nx = S_IDLE;
         default:   w_state_nx = S_IDLE;
      endcase
   end

   // RAM port and handshake values loaded on entry so they are valid throughout the state
   always_comb begin
      w_ram_addr_d  = ram_addr;
      w_ram_we_d    = 1'b0;
      w_ram_wdata_d = ram_wdata;
      w_cpu_ready_d = 1'b0;
      unique case (w_state_nx)
         S_VGA_RD: w_ram_addr_d = w_tgt_addr;
         S_CPU_RD: begin
            w_ram_addr_d  = cpu_addr;
            w_cpu_ready_d = 1'b1;
         end
         S_CPU_WR: begin
            w_ram_addr_d  = cpu_addr;
            w_ram_we_d    = 1'b1;
            w_ram_wdata_d = cpu_wdata;
            w_cpu_ready_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_wr_hit_pf   = (r_state == S_CPU_WR) && r_pf_valid && (ram_addr == r_pf_tag);
      w_wr_hit_out  = (r_state == S_CPU_WR) && r_out_valid && (ram_addr == r_out_tag);
      w_pf_data_eff = w_wr_hit_pf ? ram_wdata : r_pf_data;
      w_disp_chk    = w_in_bounds && (!r_out_valid || (w_cur_addr != r_out_tag));
      w_disp_hit    = w_disp_chk && r_pf_valid && (r_pf_tag == w_cur_addr);
      w_miss        = w_disp_chk && !w_disp_hit;
   end

   always_ff @(posedge CLK_50) begin
      if (reset) begin
         ram_addr    <= '0;
         ram_we      <= 1'b0;
         ram_wdata   <= '0;
         cpu_ready   <= 1'b0;
         cpu_rvalid  <= 1'b0;
         cpu_rdata   <= '0;
         pixel_out   <= '0;
         underrun    <= 1'b0;
         r_pf_valid  <= 1'b0;
         r_pf_tag    <= '0;
         r_pf_data   <= '0;
         r_out_valid <= 1'b0;
         r_out_tag   <= '0;
      end else begin
         ram_addr   <= w_ram_addr_d;
         ram_we     <= w_ram_we_d;
         ram_wdata  <= w_ram_wdata_d;
         cpu_ready  <= w_cpu_ready_d;
         cpu_rvalid <= (r_state == S_CPU_CAP);
         if (r_state == S_CPU_CAP) cpu_rdata <= ram_rdata;
         if (r_state == S_VGA_CAP) begin
            r_pf_data  <= ram_rdata;
            r_pf_tag   <= ram_addr;
            r_pf_valid <= 1'b1;
         end else if (w_wr_hit_pf) begin
            r_pf_data  <= ram_wdata;
         end
         // A display load takes precedence; a write to the shown word patches it in place
         if (w_disp_hit) begin
            pixel_out   <= w_pf_data_eff;
            r_out_tag   <= w_cur_addr;
            r_out_valid <= 1'b1;
         end else if (w_wr_hit_out) begin
            pixel_out   <= ram_wdata;
         end
         underrun <= underrun | w_miss;
      end
   end

`ifdef VRAM_ARB_STATS_EN
   logic w_cpu_grant;
   assign w_cpu_grant = (r_state == S_IDLE) && ((w_state_nx == S_CPU_RD) || (w_state_nx == S_CPU_WR));

   always_ff @(posedge CLK_50) begin
      if (reset) begin
         underrun_cnt  <= '0;
         cpu_stall_cnt <= '0;
      end else begin
         if (w_miss && (underrun_cnt != 16'hFFFF)) underrun_cnt <= underrun_cnt + 16'd1;
         if (cpu_req && !w_cpu_grant && !cpu_ready && (cpu_stall_cnt != 16'hFFFF))
            cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: prefetch, CPU arbitration, write coherence, underrun and address wrap.
module tb_vram_arbiter;
   localparam int unsigned RW = 16;
   localparam int unsigned AW = 10;

   logic          CLK_50 = 1'b0;
   logic          reset;
   logic [9:0]    pixel_x, pixel_y;
   logic [RW-1:0] pixel_out;
   logic          underrun;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [RW-1:0] cpu_wdata;
   logic          cpu_ready, cpu_rvalid;
   logic [RW-1:0] cpu_rdata;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [RW-1:0] ram_wdata;
   logic [RW-1:0] ram_rdata;
`ifdef VRAM_ARB_STATS_EN
   logic [15:0]   underrun_cnt, cpu_stall_cnt;
`endif

   logic [RW-1:0] mem [1024];
   logic          pre_we;
   logic [AW-1:0] pre_addr;
   logic [RW-1:0] pre_data;

   int n_cmp  = 0;
   int n_fail = 0;

   vram_arbiter dut (
      .CLK_50    (CLK_50),
      .reset     (reset),
      .pixel_x   (pixel_x),
      .pixel_y   (pixel_y),
      .pixel_out (pixel_out),
      .underrun  (underrun),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ready (cpu_ready),
      .cpu_rvalid(cpu_rvalid),
      .cpu_rdata (cpu_rdata),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
`ifdef VRAM_ARB_STATS_EN
      ,
      .underrun_cnt (underrun_cnt),
      .cpu_stall_cnt(cpu_stall_cnt)
`endif
   );

   always #10 CLK_50 = ~CLK_50;

   // Single-port synchronous RAM with a bench-side preload port
   always @(posedge CLK_50) begin
      if (pre_we)      mem[pre_addr] <= pre_data;
      else if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic tick();
      @(posedge CLK_50);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [RW-1:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      tick();
      pre_we   = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      cpu_req   = 1'b1;
      cpu_we    = 1'b0;
      cpu_addr  = 10'h123;
      cpu_wdata = '0;
      pixel_x   = 10'd600;
      pixel_y   = 10'd10;
      pre_we    = 1'b0;
      pre_addr  = '0;
      pre_data  = '0;

      // Reset with a pending CPU request; RAM preloaded meanwhile
      preload(10'd0,   16'h0F0F);
      chk("rst_ready_0", 32'(cpu_ready), 32'h0);
      preload(10'd1,   16'hA5A5);
      preload(10'd2,   16'h2222);
      chk("rst_ready_2", 32'(cpu_ready), 32'h0);
      preload(10'h123, 16'h1234);
      preload(10'd767, 16'h7777);
      chk("rst_pixel_out", 32'(pixel_out), 32'h0);
      chk("rst_underrun",  32'(underrun),  32'h0);
      chk("rst_rvalid",    32'(cpu_rvalid), 32'h0);
      chk("rst_rdata",     32'(cpu_rdata), 32'h0);
      chk("rst_ram_sigs",  32'({ram_we, ram_addr, ram_wdata}), 32'h0);

      // First cycle out of reset launches the prefetch (x in blank, y=10 -> row 2 word 0)
      reset   = 1'b0;
      cpu_req = 1'b0;
      tick();
      chk("first_vga_rd_addr", 32'(ram_addr), 32'd16);
      chk("first_vga_rd_ready", 32'(cpu_ready), 32'h0);
      tick();
      tick();
      // Vertical blank retargets to word 0
      pixel_y = 10'd500;
      repeat (3) tick();
      chk("blank_fetch0_addr", 32'(ram_addr), 32'd0);

      // Sweep x 0..63 on line 0
      for (int x = 0; x < 64; x++) begin
         pixel_x = 10'(x);
         pixel_y = 10'd0;
         tick();
         if (x == 0)  chk("sweep_x0_pix",  32'(pixel_out), 32'h0F0F);
         if (x == 63) chk("sweep_x63_pix", 32'(pixel_out), 32'h0F0F);
      end
      chk("sweep_fetch1_tag", 32'(ram_addr), 32'd1);
      pixel_x = 10'd64;
      tick();
      chk("x64_pix", 32'(pixel_out), 32'hA5A5);
      chk("x64_underrun", 32'(underrun), 32'h0);
      pixel_x = 10'd65;
      tick();
      pixel_x = 10'd66;
      tick();

      // CPU read collides with a new VGA request: VGA first, CPU after the fetch
      pixel_x  = 10'd128;
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 10'h123;
      tick();
      chk("coll_vga_addr", 32'(ram_addr), 32'd3);
      chk("coll_ready_c1", 32'(cpu_ready), 32'h0);
      chk("coll_pix_2222", 32'(pixel_out), 32'h2222);
      tick();
      chk("coll_ready_c2", 32'(cpu_ready), 32'h0);
      tick();
      chk("coll_ready_c3", 32'(cpu_ready), 32'h0);
      tick();
      chk("coll_ready_c4", 32'(cpu_ready), 32'h1);
      chk("coll_rd_addr",  32'(ram_addr),  32'h123);
      chk("coll_rd_we",    32'(ram_we),    32'h0);
      cpu_req = 1'b0;
      tick();
      chk("coll_ready_drop", 32'(cpu_ready),  32'h0);
      chk("coll_rvalid_c5",  32'(cpu_rvalid), 32'h0);
      tick();
      chk("coll_rvalid_c6", 32'(cpu_rvalid), 32'h1);
      chk("coll_rdata",     32'(cpu_rdata),  32'h1234);
      tick();
      chk("coll_rvalid_end", 32'(cpu_rvalid), 32'h0);
      chk("coll_rdata_hold", 32'(cpu_rdata),  32'h1234);
`ifdef VRAM_ARB_STATS_EN
      chk("stall_cnt", 32'(cpu_stall_cnt), 32'd3);
`endif

      // CPU write to the displayed word patches pixel_out
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 10'd2;
      cpu_wdata = 16'hFFFF;
      tick();
      chk("wr_ready", 32'(cpu_ready), 32'h1);
      chk("wr_ram",   32'({ram_we, ram_addr, ram_wdata}), {5'd0, 1'b1, 10'd2, 16'hFFFF});
      cpu_req = 1'b0;
      tick();
      chk("wr_pix_ffff", 32'(pixel_out), 32'hFFFF);
      chk("wr_we_low",   32'(ram_we),    32'h0);

      // Read back the written word from RAM
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 10'd2;
      tick();
      chk("rb_ready", 32'(cpu_ready), 32'h1);
      cpu_req = 1'b0;
      tick();
      tick();
      chk("rb_rvalid", 32'(cpu_rvalid), 32'h1);
      chk("rb_rdata",  32'(cpu_rdata),  32'hFFFF);

      // CPU write to the prefetched word reaches the display when the beam gets there
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 10'd3;
      cpu_wdata = 16'h5A5A;
      tick();
      chk("wr2_ready", 32'(cpu_ready), 32'h1);
      cpu_req = 1'b0;
      tick();
      chk("wr2_pix_hold", 32'(pixel_out), 32'hFFFF);
      pixel_x = 10'd192;
      tick();
      chk("wr2_pix_5a5a", 32'(pixel_out), 32'h5A5A);

      // Back to frame start, then jump the beam far ahead
      pixel_x = 10'd600;
      pixel_y = 10'd500;
      repeat (6) tick();
      for (int x = 0; x <= 10; x++) begin
         pixel_x = 10'(x);
         pixel_y = 10'd0;
         tick();
      end
      chk("x10_pix",      32'(pixel_out), 32'h0F0F);
      chk("x10_underrun", 32'(underrun),  32'h0);
      pixel_x = 10'd200;
      tick();
      chk("jump_underrun", 32'(underrun),  32'h1);
      chk("jump_pix_hold", 32'(pixel_out), 32'h0F0F);
      pixel_x = 10'd600;
      pixel_y = 10'd500;
      repeat (4) tick();
      chk("underrun_sticky", 32'(underrun), 32'h1);
`ifdef VRAM_ARB_STATS_EN
      chk("underrun_cnt", 32'(underrun_cnt), 32'd1);
`endif

      // Bottom-right corner: target wraps to word 0
      reset   = 1'b1;
      pixel_x = 10'd447;
      pixel_y = 10'd383;
      tick();
      tick();
      chk("rst2_underrun", 32'(underrun),  32'h0);
      chk("rst2_pix",      32'(pixel_out), 32'h0);
      reset = 1'b0;
      tick();
      chk("corner_tgt_767", 32'(ram_addr), 32'd767);
      tick();
      tick();
      pixel_x = 10'd511;
      tick();
      chk("wrap_tgt_0",  32'(ram_addr),  32'd0);
      chk("corner_pix",  32'(pixel_out), 32'h7777);
      tick();
      tick();
      pixel_x = 10'd0;
      pixel_y = 10'd0;
      tick();
      chk("wrap_pix_0f0f", 32'(pixel_out), 32'h0F0F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
